addsub_operand_sequencer: RTL and testbench

Sequential front/back-end for the 8-bit ripple-carry adder/subtractor. Accepts an operation request over a valid/ready handshake, registers the operands and the mode bit that drive the combinational adder, then captures sum, carry and overflow into a result register with derived zero and negative flags. Results go out over a second valid/ready handshake. An internal 8-bit accumulator supports chained operations.

---
 rtl/addsub_operand_sequencer.sv | 131 +++++++++++++
 tb/tb_addsub_operand_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_operand_sequencer.sv
// rtl/addsub_operand_sequencer.sv - operand/result sequencer wrapped around an external 8-bit adder/subtractor
//
// Accepts one operation per valid/ready handshake, registers the operands and
// the mode bit that drive the external ripple-carry adder, captures the adder
// outputs one cycle later and presents them over a second valid/ready handshake.
// An internal accumulator takes every result so ACC_ADD/ACC_SUB can chain.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready           request handshake
//   in_op[1:0]                   00 A+B, 01 A-B, 10 ACC+B, 11 ACC-B
//   in_a, in_b                   operands (in_a ignored for ACC ops)
//   add_a, add_b, add_m          registered operands/mode to the adder
//   add_s, add_cout, add_v       adder sum, carry-out, signed overflow
//   out_valid, out_ready         result handshake
//   out_result, out_c, out_v,
//   out_z, out_n                 captured result and flags

module addsub_operand_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_m,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             m_q;
    logic [WIDTH-1:0] acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q;
    logic             v_q;
    logic             z_q;
    logic             n_q;

    // The adder sees the operand registers directly, so its inputs stay
    // frozen outside of acceptance and it gets a full period to settle.
    assign add_a      = opa_q;
    assign add_b      = opb_q;
    assign add_m      = m_q;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_c      = c_q;
    assign out_v      = v_q;
    assign out_z      = z_q;
    assign out_n      = n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            m_q         <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered: it comes up on the first clock
                    // after reset, and no request is taken while it is low.
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        opa_q      <= in_op[1] ? acc_q : in_a;
                        opb_q      <= in_b;
                        m_q        <= in_op[0];
                        in_ready_q <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= add_s;
                    c_q         <= add_cout;
                    v_q         <= add_v;
                    z_q         <= (add_s == '0);
                    n_q         <= add_s[WIDTH-1];
                    acc_q       <= add_s;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    // Requests are never accepted here; in_ready rises on the
                    // same edge the result is consumed.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// tb/tb_addsub_operand_sequencer.sv - self-checking bench for addsub_operand_sequencer

module tb_addsub_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_m;
    logic [7:0] add_s;
    logic       add_cout;
    logic       add_v;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_c;
    logic       out_v;
    logic       out_z;
    logic       out_n;

    int checks = 0;
    int errors = 0;
    logic [7:0] acc_m;

    always #5 clk = ~clk;

    // External ripple-carry adder/subtractor: B is inverted and carry-in = M.
    logic [7:0] bx;
    logic [8:0] tsum;
    assign bx       = add_b ^ {8{add_m}};
    assign tsum     = {1'b0, add_a} + {1'b0, bx} + {8'd0, add_m};
    assign add_s    = tsum[7:0];
    assign add_cout = tsum[8];
    assign add_v    = (add_a[7] == bx[7]) && (tsum[7] != add_a[7]);

    logic [11:0] dut_res;
    assign dut_res = {out_result, out_c, out_v, out_z, out_n};

    addsub_operand_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_m(add_m),
        .add_s(add_s), .add_cout(add_cout), .add_v(add_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_c(out_c), .out_v(out_v),
        .out_z(out_z), .out_n(out_n)
    );

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [11:0] ref_op(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] acc);
        int x, y, r, sx, sy, sr;
        logic c, v;
        logic [7:0] res;
        x  = op[1] ? int'(acc) : int'(a);
        y  = int'(b);
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        if (op[0]) begin
            r = x - y; c = (x >= y); sr = sx - sy;
        end else begin
            r = x + y; c = (r > 255); sr = sx + sy;
        end
        res = r[7:0];
        v   = (sr > 127) || (sr < -128);
        return {res, c, v, (res == 8'h00), res[7]};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        int n;
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_ready_timeout in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        acc_m = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, add_a, add_b, add_m, dut_res} !== 31'd0) begin
            errors++;
            $display("FAIL reset_values got valid=%0b rdy=%0b a=%h b=%h m=%0b res=%h required all zero",
                     out_valid, in_ready, add_a, add_b, add_m, dut_res);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_before_clk got %0b required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_clk got %0b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [11:0] exp;
        exp = ref_op(2'b00, 8'h7F, 8'h01, acc_m); acc_m = exp[11:4];
        issue(2'b00, 8'h7F, 8'h01, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL add_latency got %0d required 1", lat); end
        checks++;
        if (dut_res !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_7f_01 got %h required %h", dut_res, {8'h80, 4'b0101});
        end
        checks++;
        if (dut_res !== exp) begin errors++; $display("FAIL add_model got %h required %h", dut_res, exp); end
        checks++;
        if ({add_a, add_b, add_m} !== {8'h7F, 8'h01, 1'b0}) begin
            errors++; $display("FAIL add_operands_held got %h %h %0b required 7f 01 0", add_a, add_b, add_m);
        end
        consume();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL add_handshake_release got valid=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [11:0] exp;
        exp = ref_op(2'b01, 8'h05, 8'h05, acc_m); acc_m = exp[11:4];
        issue(2'b01, 8'h05, 8'h05, lat);
        checks++;
        if (dut_res !== {8'h00, 4'b1010} || dut_res !== exp) begin
            errors++; $display("FAIL sub_05_05 got %h required %h", dut_res, {8'h00, 4'b1010});
        end
        consume();
        exp = ref_op(2'b01, 8'h00, 8'h01, acc_m); acc_m = exp[11:4];
        issue(2'b01, 8'h00, 8'h01, lat);
        checks++;
        if (dut_res !== {8'hFF, 4'b0001} || dut_res !== exp) begin
            errors++; $display("FAIL sub_00_01 got %h required %h", dut_res, {8'hFF, 4'b0001});
        end
        checks++;
        if (add_m !== 1'b1) begin errors++; $display("FAIL sub_mode got %0b required 1", add_m); end
        consume();
    endtask

    task automatic test_chain();
        int lat;
        logic [11:0] exp;
        exp = ref_op(2'b00, 8'h7F, 8'h01, acc_m); acc_m = exp[11:4];
        issue(2'b00, 8'h7F, 8'h01, lat);
        consume();
        exp = ref_op(2'b11, 8'h55, 8'h01, acc_m); acc_m = exp[11:4];
        issue(2'b11, 8'h55, 8'h01, lat);
        checks++;
        if (dut_res !== {8'h7F, 4'b1100} || dut_res !== exp) begin
            errors++; $display("FAIL chain_acc_sub got %h required %h", dut_res, {8'h7F, 4'b1100});
        end
        consume();
        exp = ref_op(2'b10, 8'hAA, 8'h81, acc_m); acc_m = exp[11:4];
        issue(2'b10, 8'hAA, 8'h81, lat);
        checks++;
        if (dut_res !== {8'h00, 4'b1010} || dut_res !== exp) begin
            errors++; $display("FAIL chain_acc_add got %h required %h", dut_res, {8'h00, 4'b1010});
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] exp, exp2;
        logic [7:0] a2, b2;
        int bad;
        exp = ref_op(2'b00, 8'($urandom), 8'($urandom), acc_m);
        issue(2'b00, 8'h00, 8'h00, lat);
        exp = ref_op(2'b00, 8'h00, 8'h00, acc_m); acc_m = exp[11:4];
        a2 = 8'($urandom); b2 = 8'($urandom);
        in_op = 2'b10; in_a = a2; in_b = b2; in_valid = 1'b1; out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (dut_res !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold got res=%h rdy=%0b valid=%0b bad_cycles=%0d required res=%h rdy=0 valid=1",
                               dut_res, in_ready, out_valid, bad, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_release got rdy=%0b valid=%0b required 1 0", in_ready, out_valid);
        end
        exp2 = ref_op(2'b10, a2, b2, acc_m); acc_m = exp2[11:4];
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got rdy=%0b required 0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || dut_res !== exp2) begin
            errors++; $display("FAIL bp_second_result got valid=%0b res=%h required 1 %h", out_valid, dut_res, exp2);
        end
        consume();
    endtask

    task automatic test_reset_mid_exec();
        int lat;
        logic [11:0] exp;
        logic seen;
        exp = ref_op(2'b00, 8'h10, 8'h20, acc_m); acc_m = exp[11:4];
        issue(2'b00, 8'h10, 8'h20, lat);
        consume();
        in_op = 2'b00; in_a = 8'h44; in_b = 8'h55; in_valid = 1'b1;
        @(posedge clk); #3;
        in_valid = 1'b0;
        rst = 1'b1; #1;
        checks++;
        if ({out_valid, in_ready, add_a, add_b, add_m, dut_res} !== 31'd0) begin
            errors++; $display("FAIL rst_mid_exec got valid=%0b rdy=%0b a=%h b=%h m=%0b res=%h required all zero",
                               out_valid, in_ready, add_a, add_b, add_m, dut_res);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        acc_m = 8'h00;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_output got valid_seen=%0b required 0", seen); end
        exp = ref_op(2'b10, 8'hEE, 8'h03, acc_m); acc_m = exp[11:4];
        issue(2'b10, 8'hEE, 8'h03, lat);
        checks++;
        if (lat != 1 || dut_res !== {8'h03, 4'b0000} || dut_res !== exp) begin
            errors++; $display("FAIL rst_first_acc_add got lat=%0d res=%h required 1 %h", lat, dut_res, {8'h03, 4'b0000});
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_q[$];
        logic [11:0] exp, got_r;
        int got, last, bad_res, bad_gap;
        logic acc_now;
        got = 0; last = -1; bad_res = 0; bad_gap = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        in_op = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
        for (int cyc = 0; cyc < 3300 && got < 1000; cyc++) begin
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                exp = ref_op(in_op, in_a, in_b, acc_m); acc_m = exp[11:4];
                exp_q.push_back(exp);
                if (last >= 0 && cyc - last != 3) bad_gap++;
                last = cyc;
                in_op = 2'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
            end
            if (out_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    bad_res++;
                end else begin
                    got_r = exp_q.pop_front();
                    if (dut_res !== got_r) begin
                        bad_res++;
                        if (bad_res <= 5) $display("FAIL b2b_result got %h required %h", dut_res, got_r);
                    end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got != 1000) begin errors++; $display("FAIL b2b_count got %0d required 1000", got); end
        checks++;
        if (bad_res != 0) begin errors++; $display("FAIL b2b_results got %0d bad required 0", bad_res); end
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL b2b_interval got %0d bad gaps required 0", bad_gap); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_chain();
        test_backpressure();
        test_reset_mid_exec();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
